// File: rtl/down_timer_ctrl_pkg.sv
// Shared definitions for the down-timer sequencer: FSM encodings and default width.
package down_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam int DEFAULT_N = 4;

endpackage

// File: rtl/down_timer_ctrl_counter.sv
// N-bit base-2 down counter with synchronous load, tick enable and borrow out.
// Saturates at zero: an enabled tick at q=0 raises eu but leaves q at 0.
module nN_b2_down_counter_load #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         ld,
    input  logic [N-1:0] d,
    input  logic         ei,
    output logic [N-1:0] q,
    output logic         eu
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;
    logic         zero;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = d;
        end else if (ei && !zero) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q  = cnt_q;
    assign eu = ei && zero;

endmodule

// File: rtl/down_timer_ctrl.sv
// Programmable delay timer: captures n on soc, counts down on enabled ticks,
// then holds until the requester releases soc before signalling eoc.
module down_timer_ctrl
    import down_timer_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         soc,
    input  logic [N-1:0] n,
    input  logic         ei,
    output logic         eoc,
    output logic [N-1:0] q,
    output logic         eu
);

    state_t state_q;
    state_t state_d;
    logic   eoc_q;
    logic   eoc_d;
    logic   ld;
    logic   cnt_ei;
    logic   cnt_eu;

    // Capture only when eoc is already high, so a stuck soc cannot retrigger
    // during the single IDLE cycle that precedes eoc rising.
    assign ld     = (state_q == IDLE) && eoc_q && soc;
    assign cnt_ei = (state_q == COUNT) && ei;

    always_comb begin
        state_d = state_q;
        eoc_d   = eoc_q;
        case (state_q)
            IDLE: begin
                if (ld) begin
                    state_d = COUNT;
                    eoc_d   = 1'b0;
                end else begin
                    eoc_d   = 1'b1;
                end
            end
            COUNT: begin
                eoc_d = 1'b0;
                if (cnt_eu) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                eoc_d = 1'b0;
                if (!soc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                eoc_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            eoc_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            eoc_q   <= eoc_d;
        end
    end

    nN_b2_down_counter_load #(
        .N(N)
    ) u_counter (
        .clock  (clock),
        .reset_ (reset_),
        .ld     (ld),
        .d      (n),
        .ei     (cnt_ei),
        .q      (q),
        .eu     (cnt_eu)
    );

    assign eoc = eoc_q;
    assign eu  = cnt_eu;

endmodule
